video_timing_meter: RTL and testbench
=====================================

Name: video_timing_meter

Overview:
- Downstream monitor for the 27 MHz test-pattern generator. Samples the generator's HSYNC, VSYNC and ENABLE on the same clk27.
- Measures line and frame timing: totals, sync widths and active sizes.
- Publishes the measurements once per frame, with a stability flag, to the status/CPU register interface.
- Used for self-test of the video path and for checking generator timing in the lab.

Parameters:
- SYNC_POL, 0, active level of hsync_in/vsync_in (0 = active-low).
- STABLE_FRAMES, 3, number of consecutive identical full-frame snapshots required before stable asserts.
- H_TIMEOUT, 2047, clocks without an hsync leading edge before the measurements are cleared.
- V_TIMEOUT, 1023, lines without a vsync leading edge before the measurements are cleared.

Ports:
- clk27  in  1  pixel clock, shared with the generator.
- reset_n  in  1  reset; asynchronous, active-low.
- hsync_in  in  1  horizontal sync from the generator.
- vsync_in  in  1  vertical sync from the generator.
- de_in  in  1  data enable from the generator.
- h_total  out  11  clocks per line.
- h_synclen  out  11  hsync width in clocks.
- h_active  out  11  DE clocks per line.
- v_total  out  11  lines per frame.
- v_synclen  out  11  vsync width in lines.
- v_active  out  11  lines containing any DE.
- frame_tick  out  1  one-cycle pulse when the outputs update.
- stable  out  1  timing unchanged for STABLE_FRAMES frames.

Behaviour:
- Reset: all outputs 0; internal state = WAIT_EDGE.
- Input stage: hsync_in, vsync_in, de_in registered once (s1), then delayed once more (s2), normalised by SYNC_POL.
  - Leading edge = s1 active and s2 inactive.
  - Outputs update on the clock edge after the edge is detected, i.e. 2 clk27 after the input transition.
- Line counters, 11-bit, saturating at 2047:
  - hcnt counts clocks since the last hsync leading edge.
  - hs_len counts clocks with sync active.
  - de_len counts DE clocks.
  - On an hsync leading edge, the values of the just-finished line are latched: line_total = hcnt + 1, line_sync, and line_de if de_len ≠ 0. Then all three counters restart.
- Frame counters, 11-bit, saturating:
  - vcnt increments on each hsync leading edge.
  - vs_len increments on each hsync leading edge seen while vsync is active.
  - va_cnt increments at an hsync leading edge if the finished line had de_len ≠ 0.
- Simultaneous hsync and vsync leading edges (the normal generator case): that line is line 0 of the new frame and counts toward v_synclen.
  - A vsync edge without a coincident hsync edge starts the frame at the next hsync edge.
- States:
  - WAIT_EDGE → first vsync edge → ARMED. The partial frame is discarded and no frame_tick is issued.
  - ARMED → next vsync edge → RUN. First full-frame snapshot is published, frame_tick pulses, match_cnt = 0.
  - RUN, each vsync edge: publish and pulse frame_tick. If the snapshot equals the previous one, match_cnt++ (saturating at STABLE_FRAMES); otherwise match_cnt = 0.
  - stable = (match_cnt == STABLE_FRAMES) and state == RUN; it is updated in the same cycle as frame_tick.
- Timeout, from any state: hcnt reaching H_TIMEOUT, or vcnt reaching V_TIMEOUT, clears all outputs to 0, clears match_cnt and stable, and returns to WAIT_EDGE. No frame_tick is issued.
- Counter saturation: a saturated count is published as 2047. A saturated snapshot never counts as a match.
- Asynchronous reset mid-frame: immediate return to the reset values; measurement restarts from WAIT_EDGE.

Decomposition:
- Shared package: state encoding, the 11-bit count width, and the default timeout constants.
- One sub-module, sync_edge_meter, instantiated twice: horizontal (counts clocks) and vertical (counts hsync edges).
  - Sub-module inputs: a sync level and an increment strobe.
  - Sub-module outputs: edge flag, total, sync length.

Test Plan:
- Nominal 720x480 generator timing (858/62/720, 525/6/480) → frame_tick pulses from the 2nd vsync edge with h_total=858, h_synclen=62, h_active=720, v_total=525, v_synclen=6, v_active=480. stable rises at the 5th vsync edge.
- Stable run, then one frame shortened to v_total=524 → stable drops at that frame_tick. It reasserts 3 matching frames later, with v_total back to 525.
- hsync held inactive for 2047 clocks → all outputs 0, stable=0, no frame_tick. Recovery: first frame_tick at the 2nd vsync edge after hsync resumes.
- vsync edge placed 100 clocks after an hsync edge (not coincident) → v_total=525 and v_synclen=6 are unchanged.
- SYNC_POL=1 with inverted syncs → the same values as the nominal scenario.
- reset_n asserted mid-frame while stable=1 → all outputs 0 immediately. After release, no frame_tick until the 2nd vsync edge.

Source files
------------

// File: rtl/video_timing_meter_pkg.sv
// video_timing_meter_pkg: shared types, widths and timeout defaults for the video timing meter.
package video_timing_meter_pkg;
  localparam int CW = 11;
  localparam logic [CW-1:0] CMAX = '1;
  localparam int H_TIMEOUT_DEF = 2047;
  localparam int V_TIMEOUT_DEF = 1023;
  typedef enum logic [1:0] {WAIT_EDGE, ARMED, RUN} state_t;
  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    cnt_t h_total;
    cnt_t h_synclen;
    cnt_t h_active;
    cnt_t v_total;
    cnt_t v_synclen;
    cnt_t v_active;
  } snap_t;
  function automatic cnt_t sat_inc(cnt_t c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/video_timing_meter_sync_edge_meter.sv
// sync_edge_meter: leading-edge detect plus period/sync-width counting over an increment strobe.
module sync_edge_meter
  import video_timing_meter_pkg::*;
#(
  parameter int TIMEOUT = H_TIMEOUT_DEF
) (
  input  logic          clk27,
  input  logic          reset_n,
  input  logic          lvl,
  input  logic          strobe,
  output logic          edge_o,
  output logic          tmo,
  output logic [CW-1:0] total,
  output logic [CW-1:0] sync_len
);
  logic lvl_q, pend_q, pend_d, rise;
  cnt_t cnt_q, cnt_d, len_q, len_d;
  // A rise between strobes is held pending so the period starts on the next strobe.
  always_comb begin
    rise = lvl & ~lvl_q;
    edge_o = strobe & (rise | pend_q);
    pend_d = (rise | pend_q) & ~strobe;
    cnt_d = edge_o ? '0 : strobe ? sat_inc(cnt_q) : cnt_q;
    len_d = edge_o ? cnt_t'(lvl) : (strobe & lvl) ? sat_inc(len_q) : len_q;
    total = sat_inc(cnt_q);
    sync_len = len_q;
    tmo = ~edge_o & (cnt_q >= cnt_t'(TIMEOUT));
  end
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      lvl_q <= lvl;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end
endmodule

// File: rtl/video_timing_meter.sv
// video_timing_meter: measures line/frame timing of a sync+DE stream and publishes it once per frame.
module video_timing_meter
  import video_timing_meter_pkg::*;
#(
  parameter bit SYNC_POL      = 1'b0,
  parameter int STABLE_FRAMES = 3,
  parameter int H_TIMEOUT     = H_TIMEOUT_DEF,
  parameter int V_TIMEOUT     = V_TIMEOUT_DEF
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [10:0] h_total,
  output logic [10:0] h_synclen,
  output logic [10:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_synclen,
  output logic [10:0] v_active,
  output logic        frame_tick,
  output logic        stable
);
  localparam logic [7:0] SF = 8'(STABLE_FRAMES);
  logic hs1_q, vs1_q, de1_q;
  logic h_edge, h_tmo, fb, v_tmo, has_de, sat, same;
  logic tick_q, tick_d, stable_q, stable_d;
  logic [7:0] match_q, match_d;
  cnt_t h_tot, h_sync, v_tot, v_sync;
  cnt_t de_q, de_d, line_de_q, line_de_d, va_q, va_d;
  snap_t snap_q, snap_d, fresh;
  state_t state_q, state_d;
  sync_edge_meter #(.TIMEOUT(H_TIMEOUT)) u_h (
    .clk27(clk27), .reset_n(reset_n), .lvl(hs1_q), .strobe(1'b1),
    .edge_o(h_edge), .tmo(h_tmo), .total(h_tot), .sync_len(h_sync)
  );
  // Vertical meter counts lines, so its frame boundary always lands on an hsync edge.
  sync_edge_meter #(.TIMEOUT(V_TIMEOUT)) u_v (
    .clk27(clk27), .reset_n(reset_n), .lvl(vs1_q), .strobe(h_edge),
    .edge_o(fb), .tmo(v_tmo), .total(v_tot), .sync_len(v_sync)
  );
  always_comb begin
    has_de = de_q != '0;
    de_d = h_edge ? cnt_t'(de1_q) : de1_q ? sat_inc(de_q) : de_q;
    line_de_d = (h_edge & has_de) ? de_q : line_de_q;
    va_d = fb ? '0 : (h_edge & has_de) ? sat_inc(va_q) : va_q;
    fresh = '{h_tot, h_sync, has_de ? de_q : line_de_q, v_tot, v_sync, has_de ? sat_inc(va_q) : va_q};
    sat = |{fresh.h_total == CMAX, fresh.h_synclen == CMAX, fresh.h_active == CMAX,
            fresh.v_total == CMAX, fresh.v_synclen == CMAX, fresh.v_active == CMAX};
    same = (fresh == snap_q) & ~sat;
    state_d = state_q;
    snap_d = snap_q;
    match_d = match_q;
    tick_d = 1'b0;
    stable_d = stable_q;
    if (h_tmo | v_tmo) begin
      state_d = WAIT_EDGE;
      snap_d = '0;
      match_d = '0;
      stable_d = 1'b0;
    end else if (fb) begin
      state_d = (state_q == WAIT_EDGE) ? ARMED : RUN;
      if (state_q != WAIT_EDGE) begin
        snap_d = fresh;
        tick_d = 1'b1;
        match_d = (state_q == RUN && same) ? ((match_q == SF) ? match_q : match_q + 1'b1) : '0;
        stable_d = match_d == SF;
      end
    end
  end
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      de_q <= '0;
      line_de_q <= '0;
      va_q <= '0;
      snap_q <= '0;
      state_q <= WAIT_EDGE;
      match_q <= '0;
      tick_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      hs1_q <= SYNC_POL ? hsync_in : ~hsync_in;
      vs1_q <= SYNC_POL ? vsync_in : ~vsync_in;
      de1_q <= de_in;
      de_q <= de_d;
      line_de_q <= line_de_d;
      va_q <= va_d;
      snap_q <= snap_d;
      state_q <= state_d;
      match_q <= match_d;
      tick_q <= tick_d;
      stable_q <= stable_d;
    end
  end
  assign h_total = snap_q.h_total;
  assign h_synclen = snap_q.h_synclen;
  assign h_active = snap_q.h_active;
  assign v_total = snap_q.v_total;
  assign v_synclen = snap_q.v_synclen;
  assign v_active = snap_q.v_active;
  assign frame_tick = tick_q;
  assign stable = stable_q;
endmodule

// File: tb/tb_video_timing_meter.sv
// tb_video_timing_meter: scaled raster (40x20) frame table with a tick scoreboard, plus timeout/reset sequences.
module tb_video_timing_meter;
  localparam int HT = 40, HS = 6, HA0 = 10, HA = 24, VS = 3, VA0 = 5, VA = 12, VOFS = 7;
  logic clk27 = 1'b0, reset_n = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0;
  logic [10:0] h_total, h_synclen, h_active, v_total, v_synclen, v_active;
  logic [10:0] h_total1, h_synclen1, h_active1, v_total1, v_synclen1, v_active1;
  logic frame_tick, stable, frame_tick1, stable1;
  typedef struct packed {
    logic [10:0] ht, hs, ha, vt, vs, va;
    logic st;
  } exp_t;
  typedef struct {
    int nl;
    int vofs;
    bit chk;
    int ev;
    bit es;
  } row_t;
  row_t rows [18];
  exp_t q [$];
  exp_t act0, act1, e_tick;
  int n_tests = 0, n_fail = 0;

  always #5 clk27 = ~clk27;

  video_timing_meter dut (
    .clk27(clk27), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .h_total(h_total), .h_synclen(h_synclen), .h_active(h_active),
    .v_total(v_total), .v_synclen(v_synclen), .v_active(v_active),
    .frame_tick(frame_tick), .stable(stable)
  );
  video_timing_meter #(.SYNC_POL(1'b1)) dut1 (
    .clk27(clk27), .reset_n(reset_n), .hsync_in(~hsync_in), .vsync_in(~vsync_in), .de_in(de_in),
    .h_total(h_total1), .h_synclen(h_synclen1), .h_active(h_active1),
    .v_total(v_total1), .v_synclen(v_synclen1), .v_active(v_active1),
    .frame_tick(frame_tick1), .stable(stable1)
  );

  assign act0 = {h_total, h_synclen, h_active, v_total, v_synclen, v_active, stable};
  assign act1 = {h_total1, h_synclen1, h_active1, v_total1, v_synclen1, v_active1, stable1};

  function automatic exp_t mk(input int vt, input bit st);
    return {11'(HT), 11'(HS), 11'(HA), 11'(vt), 11'(VS), 11'(VA), st};
  endfunction

  task automatic check(input string nm, input exp_t a, input exp_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got ht=%0d hs=%0d ha=%0d vt=%0d vs=%0d va=%0d st=%0b, want ht=%0d hs=%0d ha=%0d vt=%0d vs=%0d va=%0d st=%0b",
               nm, $time, a.ht, a.hs, a.ha, a.vt, a.vs, a.va, a.st, e.ht, e.hs, e.ha, e.vt, e.vs, e.va, e.st);
    end
  endtask

  // Active-low syncs; vofs shifts vsync against the hsync grid.
  task automatic drive_frame(input int nl, input int vofs);
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < HT; c++) begin
        @(negedge clk27);
        hsync_in = !(c < HS);
        vsync_in = !((l * HT + c) >= vofs && (l * HT + c) < vofs + VS * HT);
        de_in = (l >= VA0 && l < VA0 + VA && c >= HA0 && c < HA0 + HA);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk27);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      de_in = 1'b0;
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (rows[i].chk) q.push_back(mk(rows[i].ev, rows[i].es));
      drive_frame(rows[i].nl, rows[i].vofs);
    end
  endtask

  always @(posedge clk27) begin
    #1;
    if (frame_tick) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tick: unexpected frame_tick at %0t, want none", $time);
      end else begin
        e_tick = q.pop_front();
        check("tick", act0, e_tick);
      end
    end
  end

  initial begin
    for (int i = 0; i < 18; i++) rows[i] = '{20, (i >= 15) ? VOFS : 0, 1'b1, 20, 1'b0};
    rows[3].es = 1'b1;
    rows[4].es = 1'b1;
    rows[5].nl = 19;
    rows[5].ev = 19;
    rows[9].es = 1'b1;
    rows[10].chk = 1'b0;
    rows[14].es = 1'b1;
    rows[17].chk = 1'b0;
    idle(4);
    check("reset", act0, '0);
    reset_n = 1'b1;
    run_rows(0, 10);
    check("polarity", act1, mk(20, 1'b1));
    idle(1950);
    check("pre_timeout", act0, mk(20, 1'b1));
    idle(100);
    check("timeout", act0, '0);
    run_rows(11, 14);
    drive_frame(8, 0);
    check("pre_reset", act0, mk(20, 1'b1));
    reset_n = 1'b0;
    #1;
    check("async_reset", act0, '0);
    idle(3);
    reset_n = 1'b1;
    run_rows(15, 17);
    idle(5);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d expected ticks never seen, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
